id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus operand-forwarding logic for the 5-stage MIPS core.
- Sits directly upstream of ALU_32bit.
- Captures decoded operands and control each cycle; drives the ALU's A, B and ALUControl inputs with forwarded values.
- Provides load-use hazard detection for the hazard/stall controller.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register-file address width
CTRL_W, 4, ALUControl width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall  input  1  hold all registered contents
flush  input  1  replace stage contents with a bubble
id_valid  input  1  ID holds a real instruction
id_rs_data  input  DATA_W  register-file read data, rs
id_rt_data  input  DATA_W  register-file read data, rt
id_imm  input  DATA_W  sign-extended immediate
id_rs  input  REG_AW  rs index
id_rt  input  REG_AW  rt index
id_rd  input  REG_AW  rd index
id_alu_src  input  1  1 selects immediate for B
id_alu_control  input  CTRL_W  ALU operation
id_reg_dst  input  1  1 selects rd as destination, 0 selects rt
id_reg_write  input  1  instruction writes register file
id_mem_read  input  1  load
id_mem_write  input  1  store
id_mem_to_reg  input  1  writeback from memory
exmem_reg_write  input  1  EX/MEM writes register
exmem_rd  input  REG_AW  EX/MEM destination
exmem_alu_result  input  DATA_W  EX/MEM ALU result
memwb_reg_write  input  1  MEM/WB writes register
memwb_rd  input  REG_AW  MEM/WB destination
memwb_wb_data  input  DATA_W  MEM/WB writeback value
alu_a  output  DATA_W  ALU operand A
alu_b  output  DATA_W  ALU operand B
alu_control  output  CTRL_W  ALU operation
ex_store_data  output  DATA_W  forwarded rt value for stores
ex_dest  output  REG_AW  destination register
ex_valid  output  1  stage holds a real instruction
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  output  1 each  registered control, gated by ex_valid
load_use_hazard  output  1  ID must stall one cycle

Behaviour:
- Update priority each rising edge: reset > flush > stall > load.
- reset or flush: all registers cleared to 0, including ex_valid=0 and every control bit 0.
- With nothing forwarded after reset, outputs are alu_a=0, alu_b=0, alu_control=4'b0000, ex_dest=0.
- stall=1 (no reset/flush): every register holds its value.
- Load: captures all id_* fields; ex_dest = id_reg_dst ? id_rd : id_rt; ex_valid = id_valid.
- When id_valid=0, the stage loads a bubble: all control bits are 0.
- Latency: one cycle from ID inputs to registered fields.
- alu_a, alu_b, alu_control, ex_store_data and load_use_hazard are combinational from the registered state and the current forwarding inputs. Forwarding therefore tracks the EX/MEM and MEM/WB sources while the stage is stalled.
- Forwarding, per operand (rs → A, rt → B/store data):
  - Use EX/MEM if exmem_reg_write and exmem_rd != 0 and exmem_rd == the operand index.
  - Otherwise use MEM/WB under the same condition with memwb_*.
  - Otherwise use the registered register-file data.
  - EX/MEM always wins when both match.
  - Register 0 is never forwarded.
- alu_b = reg_alu_src ? reg_imm : forwarded rt. ex_store_data always equals forwarded rt.
- load_use_hazard = ex_valid & ex_mem_read & (ex_dest != 0) & (ex_dest == id_rs | (ex_dest == id_rt & !id_alu_src | id_mem_write)).
- The controller responds to load_use_hazard by driving id_valid=0 for that cycle; this block does not gate itself.
- No arithmetic in this block; all paths are pass-through or mux.

Decomposition:
- Shared package mips_pkg holds:
  - ALUControl encodings: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111.
  - Forward-select constants: FWD_RF=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10.
  - REG_ZERO=5'd0.
- One sub-module: forward_unit. It is combinational and produces the 2-bit select for rs and for rt from the registered indices and the exmem/memwb fields. It is instantiated once.

Test Plan:
- Reset mid-operation: load an ADD, assert reset for one cycle → next cycle ex_valid=0, all control bits 0, alu_a=0.
- No hazard: id_rs_data=5, id_rt_data=7, id_alu_control=ALU_ADD, id_alu_src=0 → one cycle later alu_a=5, alu_b=7, alu_control=4'b0010.
- Double-match priority: stage rs=3; exmem_rd=3 with exmem_alu_result=0x11; memwb_rd=3 with memwb_wb_data=0x22 → alu_a=0x11. Drop exmem_reg_write → alu_a=0x22.
- Register-0 rule: rs=0, exmem_rd=0, exmem_reg_write=1, exmem_alu_result=0xFF, id_rs_data=0 → alu_a=0.
- Load-use: EX holds lw with ex_dest=8; ID presents id_rs=8 → load_use_hazard=1. With id_rs=9, id_rt=8, id_alu_src=1, id_mem_write=0 → load_use_hazard=0.
- Stall vs flush: stall=1 holds alu_control=ALU_SUB over 3 cycles. stall=1 and flush=1 together → bubble (ex_valid=0).

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the MIPS pipeline
package mips_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - operand forwarding source selection for EX
module forward_unit
    import mips_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    output logic [1:0]        fwd_rs,
    output logic [1:0]        fwd_rt
);

    logic exmem_live;
    logic memwb_live;

    // A producer only counts if it writes a real register; r0 is hardwired zero
    assign exmem_live = exmem_reg_write && (exmem_rd != REG_ZERO);
    assign memwb_live = memwb_reg_write && (memwb_rd != REG_ZERO);

    // Youngest producer (EX/MEM) wins over MEM/WB when both match
    always_comb begin
        fwd_rs = FWD_RF;
        fwd_rt = FWD_RF;
        if (exmem_live && (exmem_rd == rs)) begin
            fwd_rs = FWD_EXMEM;
        end else if (memwb_live && (memwb_rd == rs)) begin
            fwd_rs = FWD_MEMWB;
        end
        if (exmem_live && (exmem_rd == rt)) begin
            fwd_rt = FWD_EXMEM;
        end else if (memwb_live && (memwb_rd == rt)) begin
            fwd_rt = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding and load-use detect
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_alu_src,
    input  logic [CTRL_W-1:0] id_alu_control,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_alu_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_wb_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_control,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              load_use_hazard
);

    logic [DATA_W-1:0] reg_rs_data;
    logic [DATA_W-1:0] reg_rt_data;
    logic [DATA_W-1:0] reg_imm;
    logic [REG_AW-1:0] reg_rs;
    logic [REG_AW-1:0] reg_rt;
    logic [REG_AW-1:0] reg_dest;
    logic              reg_valid;
    logic              reg_alu_src;
    logic [CTRL_W-1:0] reg_alu_control;
    logic              reg_reg_write;
    logic              reg_mem_read;
    logic              reg_mem_write;
    logic              reg_mem_to_reg;

    logic [1:0]        fwd_rs;
    logic [1:0]        fwd_rt;
    logic [DATA_W-1:0] rs_value;
    logic [DATA_W-1:0] rt_value;

    // Pipeline register: reset/flush insert a cleared bubble, stall holds, else load
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            reg_rs_data     <= '0;
            reg_rt_data     <= '0;
            reg_imm         <= '0;
            reg_rs          <= '0;
            reg_rt          <= '0;
            reg_dest        <= '0;
            reg_valid       <= 1'b0;
            reg_alu_src     <= 1'b0;
            reg_alu_control <= '0;
            reg_reg_write   <= 1'b0;
            reg_mem_read    <= 1'b0;
            reg_mem_write   <= 1'b0;
            reg_mem_to_reg  <= 1'b0;
        end else if (!stall) begin
            reg_rs_data     <= id_rs_data;
            reg_rt_data     <= id_rt_data;
            reg_imm         <= id_imm;
            reg_rs          <= id_rs;
            reg_rt          <= id_rt;
            reg_dest        <= id_reg_dst ? id_rd : id_rt;
            reg_valid       <= id_valid;
            // A non-valid ID slot becomes a bubble with every control bit cleared
            reg_alu_src     <= id_valid & id_alu_src;
            reg_alu_control <= id_valid ? id_alu_control : '0;
            reg_reg_write   <= id_valid & id_reg_write;
            reg_mem_read    <= id_valid & id_mem_read;
            reg_mem_write   <= id_valid & id_mem_write;
            reg_mem_to_reg  <= id_valid & id_mem_to_reg;
        end
    end

    forward_unit #(
        .REG_AW(REG_AW)
    ) u_forward_unit (
        .rs              (reg_rs),
        .rt              (reg_rt),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .fwd_rs          (fwd_rs),
        .fwd_rt          (fwd_rt)
    );

    // Operand muxes follow live forwarding inputs, so they stay current during a stall
    always_comb begin
        rs_value = reg_rs_data;
        rt_value = reg_rt_data;
        case (fwd_rs)
            FWD_EXMEM: rs_value = exmem_alu_result;
            FWD_MEMWB: rs_value = memwb_wb_data;
            default:   rs_value = reg_rs_data;
        endcase
        case (fwd_rt)
            FWD_EXMEM: rt_value = exmem_alu_result;
            FWD_MEMWB: rt_value = memwb_wb_data;
            default:   rt_value = reg_rt_data;
        endcase
    end

    assign alu_a         = rs_value;
    assign alu_b         = reg_alu_src ? reg_imm : rt_value;
    assign alu_control   = reg_alu_control;
    assign ex_store_data = rt_value;
    assign ex_dest       = reg_dest;
    assign ex_valid      = reg_valid;
    assign ex_reg_write  = reg_valid & reg_reg_write;
    assign ex_mem_read   = reg_valid & reg_mem_read;
    assign ex_mem_write  = reg_valid & reg_mem_write;
    assign ex_mem_to_reg = reg_valid & reg_mem_to_reg;

    // A load in EX cannot forward in time to a consumer in ID; rt only matters
    // when it feeds the ALU or is the store data
    assign load_use_hazard = ex_valid && ex_mem_read && (ex_dest != REG_ZERO) &&
                             ((ex_dest == id_rs) ||
                              ((ex_dest == id_rt) && (!id_alu_src || id_mem_write)));

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed scoreboard bench for id_ex_stage
module tb_id_ex_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic [3:0]  id_alu_control;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_alu_result, memwb_wb_data;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_control;
    logic [4:0]  ex_dest;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_hazard;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic        valid;
        logic [4:0]  dest;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_src(id_alu_src), .id_alu_control(id_alu_control), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_alu_result(exmem_alu_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_wb_data(memwb_wb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .ex_store_data(ex_store_data),
        .ex_dest(ex_dest), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .load_use_hazard(load_use_hazard)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl,
                        input logic valid, input logic [4:0] dest);
        exp_t e;
        e.a = a; e.b = b; e.ctrl = ctrl; e.valid = valid; e.dest = dest;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        tests++;
        assert (exp_q.size() > 0) else begin
            failed++;
            $error("FAIL %s_queue: observed empty expected entry", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_a"}, alu_a, e.a);
            chk({tag, "_b"}, alu_b, e.b);
            chk({tag, "_ctrl"}, {28'd0, alu_control}, {28'd0, e.ctrl});
            chk({tag, "_valid"}, {31'd0, ex_valid}, {31'd0, e.valid});
            chk({tag, "_dest"}, {27'd0, ex_dest}, {27'd0, e.dest});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_load(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                           input logic [3:0] ctrl, input logic src, input logic dst,
                           input logic rw, input logic mr, input logic mw, input logic m2r);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_alu_control = ctrl; id_alu_src = src; id_reg_dst = dst;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        id_load(0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0);
        exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_alu_result = 32'd0;
        memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_wb_data = 32'd0;

        // reset state
        push(32'd0, 32'd0, 4'b0000, 1'b0, 5'd0);
        step(); step();
        reset = 1'b0;
        pop_check("reset");
        chk("reset_ctrlbits", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 32'd0);
        chk("reset_hazard", {31'd0, load_use_hazard}, 32'd0);

        // plain ADD, no forwarding, rd destination
        id_load(1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h40, ALU_ADD, 0, 1, 1, 0, 0, 0);
        push(32'd5, 32'd7, 4'b0010, 1'b1, 5'd3);
        step();
        pop_check("add");
        chk("add_store", ex_store_data, 32'd7);
        chk("add_regwrite", {31'd0, ex_reg_write}, 32'd1);

        // reset mid-operation clears the loaded ADD
        reset = 1'b1;
        push(32'd0, 32'd0, 4'b0000, 1'b0, 5'd0);
        step();
        reset = 1'b0;
        pop_check("midreset");
        chk("midreset_ctrlbits", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 32'd0);

        // immediate operand, rt destination
        id_load(1, 5'd2, 5'd4, 5'd6, 32'd9, 32'h33, 32'h100, ALU_OR, 1, 0, 1, 0, 0, 0);
        push(32'd9, 32'h100, ALU_OR, 1'b1, 5'd4);
        step();
        pop_check("imm");
        chk("imm_store", ex_store_data, 32'h33);

        // double-match priority on rs, then EX/MEM drops out, then both drop out
        id_load(1, 5'd3, 5'd5, 5'd7, 32'hAA, 32'hBB, 32'h0, ALU_ADD, 0, 1, 1, 0, 0, 0);
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_alu_result = 32'h11;
        memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_wb_data = 32'h22;
        #1;
        push(32'h11, 32'hBB, ALU_ADD, 1'b1, 5'd7);
        pop_check("fwd_both");
        exmem_reg_write = 1'b0;
        #1;
        push(32'h22, 32'hBB, ALU_ADD, 1'b1, 5'd7);
        pop_check("fwd_memwb");
        memwb_reg_write = 1'b0;
        #1;
        chk("fwd_none_a", alu_a, 32'hAA);
        // EX/MEM forward onto rt reaches both B and store data
        exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_alu_result = 32'h5555;
        #1;
        chk("fwd_rt_b", alu_b, 32'h5555);
        chk("fwd_rt_store", ex_store_data, 32'h5555);
        exmem_reg_write = 1'b0;

        // register 0 is never forwarded
        id_load(1, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'h0, ALU_ADD, 0, 1, 1, 0, 0, 0);
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_alu_result = 32'hFF;
        memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_wb_data = 32'hEE;
        #1;
        chk("r0_a", alu_a, 32'd0);
        chk("r0_b", alu_b, 32'd0);
        exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

        // load-use: lw into r8 sits in EX
        id_load(1, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 32'h10, ALU_ADD, 1, 0, 1, 1, 0, 1);
        step();
        chk("lw_memread", {31'd0, ex_mem_read}, 32'd1);
        chk("lw_mem2reg", {31'd0, ex_mem_to_reg}, 32'd1);
        chk("lw_dest", {27'd0, ex_dest}, 32'd8);
        id_rs = 5'd8; id_rt = 5'd2; id_alu_src = 1'b0; id_mem_write = 1'b0;
        #1;
        chk("lu_rs", {31'd0, load_use_hazard}, 32'd1);
        id_rs = 5'd9; id_rt = 5'd8; id_alu_src = 1'b1; id_mem_write = 1'b0;
        #1;
        chk("lu_rt_imm", {31'd0, load_use_hazard}, 32'd0);
        id_alu_src = 1'b0;
        #1;
        chk("lu_rt_reg", {31'd0, load_use_hazard}, 32'd1);
        id_alu_src = 1'b1; id_mem_write = 1'b1;
        #1;
        chk("lu_rt_store", {31'd0, load_use_hazard}, 32'd1);

        // controller bubbles ID: control bits must not propagate
        id_load(0, 5'd8, 5'd8, 5'd0, 32'h0, 32'h0, 32'h0, ALU_ADD, 0, 0, 1, 1, 1, 1);
        step();
        chk("bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("bubble_ctrlbits", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 32'd0);
        chk("bubble_hazard", {31'd0, load_use_hazard}, 32'd0);

        // stall holds a SUB for three cycles while ID changes underneath
        id_load(1, 5'd10, 5'd11, 5'd12, 32'd1, 32'd2, 32'h0, ALU_SUB, 0, 1, 1, 0, 0, 0);
        push(32'd1, 32'd2, ALU_SUB, 1'b1, 5'd12);
        step();
        pop_check("sub");
        stall = 1'b1;
        id_load(1, 5'd13, 5'd14, 5'd15, 32'h77, 32'h88, 32'h0, ALU_AND, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            push(32'd1, 32'd2, ALU_SUB, 1'b1, 5'd12);
            step();
            pop_check("stall");
        end
        // forwarding still tracks live sources while stalled
        memwb_reg_write = 1'b1; memwb_rd = 5'd10; memwb_wb_data = 32'h99;
        #1;
        chk("stall_fwd_a", alu_a, 32'h99);
        memwb_reg_write = 1'b0;

        // flush beats stall
        flush = 1'b1;
        push(32'd0, 32'd0, 4'b0000, 1'b0, 5'd0);
        step();
        flush = 1'b0; stall = 1'b0;
        pop_check("flush");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
